assoc_cache: RTL
================

ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 Parameter WAYS, default 2: associativity; legal values 1, 2, 4.
REQ-002 Parameter SETS, default 128: number of sets; power of two, 2..1024.
REQ-003 Parameter DATA_W, default 32: data word width.
REQ-004 Parameter ADDR_W, default 32: byte address width; one word per line, index = addr[log2(SETS)+1:2], tag = addr[ADDR_W-1:log2(SETS)+2].
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 re  input  1  read request; sampled only in IDLE.
REQ-008 we  input  1  write request; sampled only in IDLE.
REQ-009 flush  input  1  invalidate-all request; sampled only in IDLE.
REQ-010 addr  input  ADDR_W  request byte address; held stable by requester until done.
REQ-011 reg_data  input  DATA_W  write data; held stable until done.
REQ-012 dout  output  DATA_W  read data; valid when done pulses after a read; held until next read completes.
REQ-013 done  output  1  one-cycle pulse marking completion of a read, write or flush.
REQ-014 cache_busy  output  1  high in every state except IDLE.
REQ-015 mainmem_access  output  1  main-memory transaction request.
REQ-016 mainmem_we  output  1  1 = memory write, 0 = memory read; valid while mainmem_access=1.
REQ-017 mainmem_addr  output  ADDR_W  registered copy of addr, word-aligned (bits [1:0]=0).
REQ-018 mainmem_wdata  output  DATA_W  registered copy of reg_data.
REQ-019 dram_data  input  DATA_W  memory read data; valid in the cycle mainmem_busy is first low in MISS_WAIT.
REQ-020 mainmem_busy  input  1  memory busy; transaction complete on first cycle it is 0 in a WAIT state.
REQ-021 hit_count, miss_count  output  32 each  lookup statistics.

Function
REQ-022 FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, WR_REQ, WR_WAIT, FLUSH.
REQ-023 IDLE priority: flush > we > re; accepted request registers addr/reg_data and moves to LOOKUP (FLUSH for flush) next cycle; no request stays IDLE.
REQ-024 LOOKUP: compare tag against all WAYS valid entries of the indexed set; hit = any match; at most one way may match.
REQ-025 Read hit: done=1 and dout=hit-way data in cycle after LOOKUP (total latency 2 cycles from acceptance), return to IDLE; hit way becomes MRU.
REQ-026 Read miss: MISS_REQ for one cycle (mainmem_access=1, mainmem_we=0), then MISS_WAIT holding mainmem_access=1 until mainmem_busy=0; that cycle write {valid,tag,dram_data} to victim way, dout=dram_data, done=1 next cycle, victim becomes MRU, IDLE.
REQ-027 Victim: lowest-index invalid way; if none, the LRU way.
REQ-028 LRU: per-way age of log2(WAYS) bits per set; on access, accessed way age=0, ways younger than its old age increment; ages always a permutation of 0..WAYS-1; WAYS=1 has no LRU state.
REQ-029 Write: write-through, no-write-allocate; on hit, update hit-way data in LOOKUP and mark MRU; on miss, no array change; both proceed WR_REQ (mainmem_we=1) then WR_WAIT until mainmem_busy=0, then done=1, IDLE.
REQ-030 mainmem_access deasserts in the cycle after completion; never high in IDLE, LOOKUP or FLUSH.
REQ-031 FLUSH: clear valid bits of one set per cycle, index 0 to SETS-1, SETS cycles; done=1 in the last cycle; LRU ages reset to way index.
REQ-032 hit_count/miss_count increment once per read or write lookup; saturate at 32'hFFFFFFFF; not cleared by flush.
REQ-033 re/we/flush asserted while cache_busy=1 are ignored.
REQ-034 Valid bits and LRU state are flops; tag/data arrays need no reset.

Reset
REQ-035 rst=0 asynchronously forces IDLE, clears all valid bits, LRU ages to way index, counters to 0, dout to 0, done/cache_busy/mainmem_access/mainmem_we to 0, mainmem_addr/mainmem_wdata to 0.
REQ-036 Reset mid-transaction aborts it with no array update and no done pulse; first request accepted on first rising edge with rst=1.

Verification
REQ-037 Read 0x100 after reset, memory returns 0xDEADBEEF after 3 busy cycles -> miss, dout=0xDEADBEEF, miss_count=1; re-read -> done 2 cycles after accept, no mainmem_access, hit_count=1.
REQ-038 WAYS=2, SETS=128: read 0x000, 0x200, 0x400 (same set) then 0x000 -> third fill evicts 0x000 line wait: first access to 0x000 after 0x400 refill misses, 0x200 evicted if 0x000 re-read before 0x400 (LRU order checked).
REQ-039 Write 0x100=0x12345678 on cached line -> mainmem_we=1, wdata 0x12345678; later read hits with 0x12345678; write to uncached 0x300 -> later read misses.
REQ-040 flush with SETS=128 -> cache_busy high 128 cycles, done on last; prior hits now miss; counters unchanged.
REQ-041 Drop rst during MISS_WAIT -> mainmem_access low immediately, no done, next read of same address misses.

Source files
------------

// File: rtl/assoc_cache.sv
// Set-associative, write-through/no-write-allocate cache with true-LRU replacement.
// One word per line; read misses and all writes go through a single memory handshake.

module assoc_cache_way #(
  parameter int SETS   = 128,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 23,
  parameter int IDX_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  input  logic              fill,
  input  logic              upd,
  input  logic              inv,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [DATA_W-1:0] wdata,
  output logic              vld,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] data
);
  logic [SETS-1:0]   vld_q;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [DATA_W-1:0] data_mem [SETS];

  always_ff @(posedge clk or negedge rst)
    if (!rst)      vld_q <= '0;
    else if (inv)  vld_q[idx] <= 1'b0;
    else if (fill) vld_q[idx] <= 1'b1;

  // tag/data carry no reset; valid bits gate them
  always_ff @(posedge clk) begin
    if (fill)        tag_mem[idx]  <= wtag;
    if (fill || upd) data_mem[idx] <= wdata;
  end

  assign vld  = vld_q[idx];
  assign tag  = tag_mem[idx];
  assign data = data_mem[idx];
endmodule

module assoc_cache #(
  parameter int WAYS   = 2,
  parameter int SETS   = 128,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic              we,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] reg_data,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              cache_busy,
  output logic              mainmem_access,
  output logic              mainmem_we,
  output logic [ADDR_W-1:0] mainmem_addr,
  output logic [DATA_W-1:0] mainmem_wdata,
  input  logic [DATA_W-1:0] dram_data,
  input  logic              mainmem_busy,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_MISS_REQ  = 3'd2;
  localparam logic [2:0] S_MISS_WAIT = 3'd3;
  localparam logic [2:0] S_WR_REQ    = 3'd4;
  localparam logic [2:0] S_WR_WAIT   = 3'd5;
  localparam logic [2:0] S_FLUSH     = 3'd6;

  logic [2:0]                  state;
  logic                        op_wr, done_q, fill, acc_en;
  logic [IDX_W-1:0]            flush_idx, idx;
  logic [TAG_W-1:0]            req_tag;
  logic [DATA_W-1:0]           way_wdata, hit_data;
  logic [WAYS-1:0]             way_vld, hit_vec, fill_vec, upd_vec;
  logic [WAYS-1:0][TAG_W-1:0]  way_tag;
  logic [WAYS-1:0][DATA_W-1:0] way_data;
  logic [AGE_W-1:0]            hit_way, vict_way, lru_way, acc_way;

  assign req_tag   = mainmem_addr[ADDR_W-1:IDX_W+2];
  assign idx       = (state == S_FLUSH) ? flush_idx : mainmem_addr[IDX_W+1:2];
  assign fill      = (state == S_MISS_WAIT) && !mainmem_busy;
  assign way_wdata = fill ? dram_data : mainmem_wdata;

  assign cache_busy     = (state != S_IDLE);
  assign mainmem_access = (state == S_MISS_REQ) || (state == S_MISS_WAIT) ||
                          (state == S_WR_REQ)   || (state == S_WR_WAIT);
  assign mainmem_we     = (state == S_WR_REQ) || (state == S_WR_WAIT);
  assign done           = done_q || (state == S_FLUSH && flush_idx == IDX_W'(SETS-1));

  always_comb begin
    hit_vec  = '0;
    hit_way  = '0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = way_vld[w] && (way_tag[w] == req_tag);
      if (hit_vec[w]) begin
        hit_way  = AGE_W'(w);
        hit_data = way_data[w];
      end
    end
  end

  // lowest-index invalid way wins over the LRU way
  always_comb begin
    vict_way = lru_way;
    for (int w = WAYS-1; w >= 0; w--)
      if (!way_vld[w]) vict_way = AGE_W'(w);
  end

  assign acc_en  = ((state == S_LOOKUP) && (|hit_vec)) || fill;
  assign acc_way = fill ? vict_way : hit_way;

  always_comb begin
    fill_vec = '0;
    upd_vec  = '0;
    for (int w = 0; w < WAYS; w++) begin
      fill_vec[w] = fill && (vict_way == AGE_W'(w));
      upd_vec[w]  = (state == S_LOOKUP) && op_wr && hit_vec[w];
    end
  end

  generate
    for (genvar w = 0; w < WAYS; w++) begin : g_way
      assoc_cache_way #(.SETS(SETS), .DATA_W(DATA_W), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_way (
        .clk(clk), .rst(rst), .idx(idx), .fill(fill_vec[w]), .upd(upd_vec[w]),
        .inv(state == S_FLUSH), .wtag(req_tag), .wdata(way_wdata),
        .vld(way_vld[w]), .tag(way_tag[w]), .data(way_data[w])
      );
    end

    if (WAYS > 1) begin : g_lru
      logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] age;
      logic [WAYS-1:0][AGE_W-1:0]           cur;
      assign cur = age[idx];

      always_comb begin
        lru_way = '0;
        for (int w = 0; w < WAYS; w++)
          if (cur[w] == AGE_W'(WAYS-1)) lru_way = AGE_W'(w);
      end

      // accessed way goes to age 0; only ways younger than it age by one
      always_ff @(posedge clk or negedge rst)
        if (!rst) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) age[s][w] <= AGE_W'(w);
        end else if (state == S_FLUSH) begin
          for (int w = 0; w < WAYS; w++) age[idx][w] <= AGE_W'(w);
        end else if (acc_en) begin
          for (int w = 0; w < WAYS; w++)
            if (AGE_W'(w) == acc_way)       age[idx][w] <= '0;
            else if (cur[w] < cur[acc_way]) age[idx][w] <= cur[w] + 1'b1;
        end
    end else begin : g_nolru
      assign lru_way = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state         <= S_IDLE;
      op_wr         <= 1'b0;
      done_q        <= 1'b0;
      dout          <= '0;
      mainmem_addr  <= '0;
      mainmem_wdata <= '0;
      flush_idx     <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE:
          if (flush) begin
            state     <= S_FLUSH;
            flush_idx <= '0;
          end else if (we || re) begin
            state         <= S_LOOKUP;
            op_wr         <= we;
            mainmem_addr  <= addr & ~ADDR_W'(3);
            mainmem_wdata <= reg_data;
          end
        S_LOOKUP: begin
          if (|hit_vec) begin
            if (hit_count != '1) hit_count <= hit_count + 32'd1;
          end else if (miss_count != '1) miss_count <= miss_count + 32'd1;
          if (op_wr) state <= S_WR_REQ;
          else if (|hit_vec) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
            dout   <= hit_data;
          end else state <= S_MISS_REQ;
        end
        S_MISS_REQ: state <= S_MISS_WAIT;
        S_MISS_WAIT:
          if (!mainmem_busy) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
            dout   <= dram_data;
          end
        S_WR_REQ: state <= S_WR_WAIT;
        S_WR_WAIT:
          if (!mainmem_busy) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        S_FLUSH: begin
          flush_idx <= flush_idx + 1'b1;
          if (flush_idx == IDX_W'(SETS-1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule
